uart_bridge_sched: RTL and testbench

Byte-forwarding scheduler that sits beside the dual-port UART block and relays traffic between its master and slave links. Bytes received on the master link are buffered and transmitted on the slave link, and slave bytes are relayed back to the master link the same way. Each direction has its own FIFO and transmit sequencer. The block drops corrupted and overflowing bytes and keeps sticky and counted error status for the host.

---
 rtl/uart_bridge_sched.sv | 172 +++++++++++++++++
 tb/tb_uart_bridge_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bridge_sched.sv
`timescale 1ns/1ps
// uart_bridge_sched: relays master-link bytes to the slave link and back through one FIFO
// and one transmit sequencer per direction, dropping bad or overflowing bytes with host status.
module uart_bridge_sched #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ACK_TIMEOUT = 63
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    master_valid,
    input  logic [7:0]              master_rx_data,
    input  logic                    master_cbe,
    input  logic                    master_sbe,
    input  logic                    master_ready,
    output logic                    master_send,
    output logic [7:0]              master_tx_data,
    input  logic                    slave_valid,
    input  logic [7:0]              slave_rx_data,
    input  logic                    slave_cbe,
    input  logic                    slave_sbe,
    input  logic                    slave_ready,
    output logic                    slave_send,
    output logic [7:0]              slave_tx_data,
    output logic [$clog2(DEPTH):0]  m2s_level,
    output logic [$clog2(DEPTH):0]  s2m_level,
    output logic                    m2s_ovf,
    output logic                    s2m_ovf,
    output logic [7:0]              m_err_cnt,
    output logic [7:0]              s_err_cnt,
    output logic                    ack_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_LOW
    } seq_state_t;

    // Lane 0 carries master->slave traffic, lane 1 carries slave->master traffic.
    logic [1:0]      rx_valid;
    logic [1:0]      rx_bad;
    logic [1:0]      tx_ready;
    logic [1:0]      ack_hit;
    logic [1:0][7:0] rx_data;

    assign rx_valid = {slave_valid, master_valid};
    assign rx_bad   = {slave_cbe | slave_sbe, master_cbe | master_sbe};
    assign tx_ready = {master_ready, slave_ready};
    assign rx_data  = {slave_rx_data, master_rx_data};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        seq_state_t    state;
        logic [7:0]    mem [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [LW-1:0] count;
        logic [TW-1:0] timer;
        logic          send_q;
        logic [7:0]    tx_q;
        logic          ovf_q;
        logic [7:0]    err_cnt;
        logic          full;
        logic          empty;
        logic          push;
        logic          pop;

        assign full  = (count == LW'(DEPTH));
        assign empty = (count == '0);
        // full is judged before this cycle's pop, so a simultaneous pop never frees a slot
        assign push  = rx_valid[g] & ~rx_bad[g] & ~full & ~clear;
        assign pop   = (state == ST_SEND) & ~clear;
        assign ack_hit[g] = (state == ST_WAIT_LOW) & tx_ready[g] & (timer == '0);

        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= rx_data[g];
        end

        // FIFO pointers and occupancy
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + LW'(1);
                    2'b01:   count <= count - LW'(1);
                    default: count <= count;
                endcase
            end
        end

        // Transmit sequencer: one-cycle send, then wait for the transmitter to go busy
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= ST_IDLE;
                send_q <= 1'b0;
                tx_q   <= 8'h00;
                timer  <= '0;
            end else begin
                send_q <= 1'b0;
                if (clear) begin
                    state <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (!empty && tx_ready[g]) begin
                                state  <= ST_SEND;
                                send_q <= 1'b1;
                                tx_q   <= mem[rd_ptr];
                            end
                        end
                        ST_SEND: begin
                            state <= ST_WAIT_LOW;
                            timer <= TW'(ACK_TIMEOUT);
                        end
                        ST_WAIT_LOW: begin
                            if (!tx_ready[g] || timer == '0) state <= ST_IDLE;
                            else timer <= timer - TW'(1);
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end

        // Receive-side status: sticky overflow and saturating framing-error count
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovf_q   <= 1'b0;
                err_cnt <= 8'h00;
            end else if (clear) begin
                ovf_q   <= 1'b0;
                err_cnt <= 8'h00;
            end else if (rx_valid[g]) begin
                if (rx_bad[g]) begin
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end else if (full) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ack_err <= 1'b0;
        else if (clear)      ack_err <= 1'b0;
        else if (|ack_hit)   ack_err <= 1'b1;
    end

    assign slave_send     = g_lane[0].send_q;
    assign slave_tx_data  = g_lane[0].tx_q;
    assign master_send    = g_lane[1].send_q;
    assign master_tx_data = g_lane[1].tx_q;
    assign m2s_level      = g_lane[0].count;
    assign s2m_level      = g_lane[1].count;
    assign m2s_ovf        = g_lane[0].ovf_q;
    assign s2m_ovf        = g_lane[1].ovf_q;
    assign m_err_cnt      = g_lane[0].err_cnt;
    assign s_err_cnt      = g_lane[1].err_cnt;

endmodule

// File: tb/tb_uart_bridge_sched.sv
`timescale 1ns/1ps
// tb_uart_bridge_sched: receive-rule vector table, directed relay/overflow/timeout/clear/reset
// sequences, and a randomized run scored against a queue-level model of both directions.
module tb_uart_bridge_sched;
    localparam int DEPTH = 16;
    localparam int T     = 12;

    logic       clk = 1'b0;
    logic       rst_n, clear;
    logic       master_valid, master_cbe, master_sbe, master_ready, master_send;
    logic [7:0] master_rx_data, master_tx_data;
    logic       slave_valid, slave_cbe, slave_sbe, slave_ready, slave_send;
    logic [7:0] slave_rx_data, slave_tx_data;
    logic [4:0] m2s_level, s2m_level;
    logic       m2s_ovf, s2m_ovf, ack_err;
    logic [7:0] m_err_cnt, s_err_cnt;

    always #5 clk = ~clk;

    uart_bridge_sched #(.DEPTH(DEPTH), .ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .master_valid(master_valid), .master_rx_data(master_rx_data),
        .master_cbe(master_cbe), .master_sbe(master_sbe), .master_ready(master_ready),
        .master_send(master_send), .master_tx_data(master_tx_data),
        .slave_valid(slave_valid), .slave_rx_data(slave_rx_data),
        .slave_cbe(slave_cbe), .slave_sbe(slave_sbe), .slave_ready(slave_ready),
        .slave_send(slave_send), .slave_tx_data(slave_tx_data),
        .m2s_level(m2s_level), .s2m_level(s2m_level),
        .m2s_ovf(m2s_ovf), .s2m_ovf(s2m_ovf),
        .m_err_cnt(m_err_cnt), .s_err_cnt(s_err_cnt), .ack_err(ack_err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        bit clr, mv, mc, ms, sv, sc, ss;
        int ml, sl, me, se;
    } vec_t;
    vec_t tbl[8];

    // Reference model state for the randomized run (index 0 = m2s, 1 = s2m)
    logic [7:0] mq [2][$];
    bit         rq [2][$];
    int         errc [2];
    bit         ovfm [2];
    bit         armed [2];
    int         wcnt [2];
    bit         ack_m;
    logic [1:0] snd, psnd, rdy_now, rdy_prev, v, ce, se;
    logic [7:0] txd [2];
    logic [7:0] rxd [2];
    int         lvl [2], ovfv [2], errv [2];
    bit         full;
    logic [7:0] got [$];
    int         hold, sends_m, sends_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_master_send"}, 32'(master_send), 0);
        check({tag, "_slave_send"}, 32'(slave_send), 0);
        check({tag, "_master_tx"}, 32'(master_tx_data), 0);
        check({tag, "_slave_tx"}, 32'(slave_tx_data), 0);
        check({tag, "_levels"}, 32'({m2s_level, s2m_level}), 0);
        check({tag, "_ovf"}, 32'({m2s_ovf, s2m_ovf}), 0);
        check({tag, "_err_cnts"}, 32'({m_err_cnt, s_err_cnt}), 0);
        check({tag, "_ack_err"}, 32'(ack_err), 0);
    endtask

    task automatic idle_inputs();
        clear = 0;
        master_valid = 0; master_cbe = 0; master_sbe = 0;
        slave_valid = 0; slave_cbe = 0; slave_sbe = 0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        idle_inputs();
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    task automatic count_sends(input int n, output int ms, output int ss);
        ms = 0;
        ss = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ms += int'(master_send);
            ss += int'(slave_send);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        master_ready = 0; slave_ready = 0;
        master_rx_data = 0; slave_rx_data = 0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1;

        // Receive-side rules, both transmitters held busy
        tbl[0] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[1] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0};
        tbl[2] = '{0, 1, 0, 1, 1, 0, 0, 1, 1, 2, 0};
        tbl[3] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 1};
        tbl[4] = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 2, 1};
        tbl[5] = '{0, 1, 0, 0, 1, 0, 0, 2, 2, 2, 1};
        tbl[6] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clear = tbl[i].clr;
            master_valid = tbl[i].mv; master_cbe = tbl[i].mc; master_sbe = tbl[i].ms;
            slave_valid = tbl[i].sv; slave_cbe = tbl[i].sc; slave_sbe = tbl[i].ss;
            master_rx_data = 8'($urandom); slave_rx_data = 8'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_m2s_level", i), 32'(m2s_level), 32'(tbl[i].ml));
            check($sformatf("tbl%0d_s2m_level", i), 32'(s2m_level), 32'(tbl[i].sl));
            check($sformatf("tbl%0d_m_err", i), 32'(m_err_cnt), 32'(tbl[i].me));
            check($sformatf("tbl%0d_s_err", i), 32'(s_err_cnt), 32'(tbl[i].se));
        end

        // Single relay: two cycles from valid to send, level 0->1->0
        pulse_clear();
        slave_ready = 1;
        @(negedge clk);
        master_valid = 1; master_rx_data = 8'hA5;
        @(negedge clk);
        master_valid = 0;
        check("relay_level_push", 32'(m2s_level), 1);
        check("relay_no_send_yet", 32'(slave_send), 0);
        @(negedge clk);
        check("relay_send", 32'(slave_send), 1);
        check("relay_tx_data", 32'(slave_tx_data), 8'hA5);
        check("relay_level_in_send", 32'(m2s_level), 1);
        @(negedge clk);
        check("relay_send_one_cycle", 32'(slave_send), 0);
        check("relay_level_after", 32'(m2s_level), 0);
        @(negedge clk);
        slave_ready = 0;
        @(negedge clk);
        @(negedge clk);
        slave_ready = 1;
        count_sends(5, sends_m, sends_s);
        check("relay_no_extra_send", 32'(sends_m + sends_s), 0);
        check("relay_tx_hold", 32'(slave_tx_data), 8'hA5);
        check("relay_no_ack_err", 32'(ack_err), 0);

        // Overflow: 17 pushes into a 16-entry FIFO, the last is dropped
        slave_ready = 0;
        pulse_clear();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            master_valid = 1; master_rx_data = 8'(i);
        end
        @(negedge clk);
        master_valid = 0;
        check("ovf_level_full", 32'(m2s_level), 16);
        check("ovf_flag", 32'(m2s_ovf), 1);
        slave_ready = 1;
        got.delete();
        hold = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (slave_send) begin
                got.push_back(slave_tx_data);
                slave_ready = 0;
                hold = 2;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) slave_ready = 1;
            end
        end
        check("ovf_sent_count", 32'(got.size()), 16);
        for (int i = 0; i < got.size() && i < 16; i++)
            check($sformatf("ovf_order%0d", i), 32'(got[i]), 32'(i));
        check("ovf_drained_level", 32'(m2s_level), 0);
        check("ovf_sticky", 32'(m2s_ovf), 1);

        // Framing errors saturate the slave error count and never reach the master link
        master_ready = 1;
        pulse_clear();
        check("clear_ovf", 32'(m2s_ovf), 0);
        sends_m = 0;
        for (int i = 0; i < 303; i++) begin
            @(negedge clk);
            if (i == 3) check("ferr_cnt_after_cbe", 32'(s_err_cnt), 3);
            sends_m += int'(master_send);
            slave_valid = 1; slave_cbe = (i < 3); slave_sbe = (i >= 3);
            slave_rx_data = 8'($urandom);
        end
        @(negedge clk);
        idle_inputs();
        sends_m += int'(master_send);
        check("ferr_saturated", 32'(s_err_cnt), 255);
        check("ferr_level", 32'(s2m_level), 0);
        check("ferr_no_master_send", 32'(sends_m), 0);
        check("ferr_m_err_untouched", 32'(m_err_cnt), 0);

        // Ack timeout: ready never falls after a send
        master_ready = 0;
        pulse_clear();
        slave_ready = 1;
        @(negedge clk);
        master_valid = 1; master_rx_data = 8'h11;
        @(negedge clk);
        master_rx_data = 8'h22;
        @(negedge clk);
        master_valid = 0;
        check("ack_first_send", 32'(slave_send), 1);
        check("ack_first_tx", 32'(slave_tx_data), 8'h11);
        for (int k = 1; k <= T + 1; k++) begin
            @(negedge clk);
            check($sformatf("ack_wait_nosend%0d", k), 32'(slave_send), 0);
        end
        check("ack_not_yet", 32'(ack_err), 0);
        @(negedge clk);
        check("ack_err_set", 32'(ack_err), 1);
        check("ack_idle_nosend", 32'(slave_send), 0);
        @(negedge clk);
        check("ack_next_send", 32'(slave_send), 1);
        check("ack_next_tx", 32'(slave_tx_data), 8'h22);
        slave_ready = 0;
        repeat (3) @(negedge clk);

        // Both FIFOs at level 5 with status set, then clear
        @(negedge clk);
        master_valid = 1; master_cbe = 1; slave_valid = 1; slave_sbe = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            master_cbe = 0; slave_sbe = 0;
            master_rx_data = 8'($urandom); slave_rx_data = 8'($urandom);
        end
        @(negedge clk);
        idle_inputs();
        check("clr_pre_m2s_level", 32'(m2s_level), 5);
        check("clr_pre_s2m_level", 32'(s2m_level), 5);
        check("clr_pre_errs", 32'({m_err_cnt, s_err_cnt}), 16'h0101);
        check("clr_pre_ack", 32'(ack_err), 1);
        clear = 1;
        @(negedge clk);
        clear = 0;
        check("clr_levels", 32'({m2s_level, s2m_level}), 0);
        check("clr_errs", 32'({m_err_cnt, s_err_cnt}), 0);
        check("clr_ack", 32'(ack_err), 0);
        check("clr_ovf", 32'({m2s_ovf, s2m_ovf}), 0);
        master_ready = 1; slave_ready = 1;
        count_sends(20, sends_m, sends_s);
        check("clr_no_sends", 32'(sends_m + sends_s), 0);

        // Randomized bidirectional traffic against the queue model
        pulse_clear();
        for (int l = 0; l < 2; l++) begin
            mq[l].delete(); rq[l].delete();
            errc[l] = 0; ovfm[l] = 0; armed[l] = 0; wcnt[l] = 0;
        end
        ack_m = 0;
        psnd = 2'b00;
        rdy_prev = 2'b11;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            snd = {master_send, slave_send};
            txd[0] = slave_tx_data; txd[1] = master_tx_data;
            lvl[0] = int'(m2s_level); lvl[1] = int'(s2m_level);
            ovfv[0] = int'(m2s_ovf); ovfv[1] = int'(s2m_ovf);
            errv[0] = int'(m_err_cnt); errv[1] = int'(s_err_cnt);
            for (int l = 0; l < 2; l++) begin
                check($sformatf("rnd%0d_level", l), 32'(lvl[l]), 32'(mq[l].size()));
                check($sformatf("rnd%0d_ovf", l), 32'(ovfv[l]), 32'(ovfm[l]));
                check($sformatf("rnd%0d_err_cnt", l), 32'(errv[l]), 32'(errc[l]));
                if (snd[l]) begin
                    check($sformatf("rnd%0d_send_has_data", l), 32'(mq[l].size() != 0), 1);
                    if (mq[l].size() != 0)
                        check($sformatf("rnd%0d_tx_data", l), 32'(txd[l]), 32'(mq[l][0]));
                    check($sformatf("rnd%0d_send_spacing", l), 32'(psnd[l]), 0);
                    check($sformatf("rnd%0d_send_needs_ready", l), 32'(rdy_prev[l]), 1);
                end
            end
            check("rnd_ack_err", 32'(ack_err), 32'(ack_m));
            for (int l = 0; l < 2; l++) begin
                if (snd[l]) begin
                    rq[l].delete();
                    if ($urandom_range(0, 9) == 0) begin
                        repeat (T + 3) rq[l].push_back(1'b1);
                    end else begin
                        repeat ($urandom_range(0, 2)) rq[l].push_back(1'b1);
                        repeat ($urandom_range(1, 5)) rq[l].push_back(1'b0);
                    end
                end
                if (rq[l].size() != 0) rdy_now[l] = rq[l].pop_front();
                else rdy_now[l] = ($urandom_range(0, 3) != 0);
                v[l]   = ($urandom_range(0, 7) < (((cyc / 500) % 2 == 1) ? 4 : 1));
                ce[l]  = ($urandom_range(0, 9) == 0);
                se[l]  = ($urandom_range(0, 9) == 0);
                rxd[l] = 8'($urandom);
            end
            master_valid = v[0]; master_cbe = ce[0]; master_sbe = se[0]; master_rx_data = rxd[0];
            slave_valid = v[1]; slave_cbe = ce[1]; slave_sbe = se[1]; slave_rx_data = rxd[1];
            slave_ready = rdy_now[0]; master_ready = rdy_now[1];
            for (int l = 0; l < 2; l++) begin
                if (armed[l]) begin
                    if (!rdy_now[l]) armed[l] = 0;
                    else if (wcnt[l] == T) begin ack_m = 1; armed[l] = 0; end
                    else wcnt[l]++;
                end
                if (snd[l]) begin armed[l] = 1; wcnt[l] = 0; end
                full = (mq[l].size() == DEPTH);
                if (snd[l] && mq[l].size() != 0) void'(mq[l].pop_front());
                if (v[l]) begin
                    if (ce[l] || se[l]) begin
                        if (errc[l] < 255) errc[l]++;
                    end else if (!full) mq[l].push_back(rxd[l]);
                    else ovfm[l] = 1;
                end
            end
            psnd = snd;
            rdy_prev = rdy_now;
        end
        @(negedge clk);
        idle_inputs();

        // Asynchronous reset while the slave sequencer is waiting for ready to fall
        pulse_clear();
        master_ready = 1; slave_ready = 1;
        @(negedge clk);
        master_valid = 1; master_rx_data = 8'h5A;
        @(negedge clk);
        master_rx_data = 8'h6B;
        @(negedge clk);
        master_rx_data = 8'h7C;
        check("arst_send", 32'(slave_send), 1);
        check("arst_tx", 32'(slave_tx_data), 8'h5A);
        @(posedge clk);
        #2;
        idle_inputs();
        check("arst_pre_level", 32'(m2s_level), 2);
        rst_n = 0;
        #1;
        check_reset_vals("arst_now");
        count_sends(2, sends_m, sends_s);
        check("arst_no_send_in_reset", 32'(sends_m + sends_s), 0);
        rst_n = 1;
        count_sends(5, sends_m, sends_s);
        check("arst_no_send_after", 32'(sends_m + sends_s), 0);
        check("arst_level_after", 32'({m2s_level, s2m_level}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
